// File: rtl/grf_writeback.sv
// Writeback stage: selects WD, commits to the 32x32 register file, bypassed reads, commit trace, retire count.
// Latency: WD/we_eff/RD combinational; array, trace and instret update on the rising edge after commit.
// No backpressure: a W instruction always retires in its cycle; the stage never stalls upstream.
module grf_writeback #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             W_valid,
  input  logic             RFWr,
  input  logic [1:0]       WDSel,
  input  logic [4:0]       A3,
  input  logic [WIDTH-1:0] AO,
  input  logic [WIDTH-1:0] DR,
  input  logic [WIDTH-1:0] W_PC,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic [WIDTH-1:0] WD,
  output logic             we_eff,
  output logic             trace_we,
  output logic [4:0]       trace_addr,
  output logic [WIDTH-1:0] trace_data,
  output logic [WIDTH-1:0] trace_pc,
  output logic [31:0]      instret
);

  localparam logic [1:0] SEL_AO  = 2'b00;
  localparam logic [1:0] SEL_DR  = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;
  localparam logic [1:0] SEL_RSV = 2'b11;

  // jal link address is two instructions past the jal (delay slot skipped)
  localparam logic [WIDTH-1:0] LINK_OFS = WIDTH'(8);

  logic [WIDTH-1:0] regs_q [0:NREG-1];
  logic [WIDTH-1:0] regs_d [0:NREG-1];

  logic             trace_we_q,   trace_we_d;
  logic [4:0]       trace_addr_q, trace_addr_d;
  logic [WIDTH-1:0] trace_data_q, trace_data_d;
  logic [WIDTH-1:0] trace_pc_q,   trace_pc_d;
  logic [31:0]      instret_q,    instret_d;

  // Writeback data select; the reserved encoding yields zero and never writes
  always_comb begin
    WD = '0;
    case (WDSel)
      SEL_AO:  WD = AO;
      SEL_DR:  WD = DR;
      SEL_PC:  WD = W_PC + LINK_OFS;
      default: WD = '0;
    endcase
  end

  // Effective write: real instruction, write enabled, not $0, not reserved select
  always_comb begin
    we_eff = W_valid & RFWr & (A3 != 5'd0) & (WDSel != SEL_RSV);
  end

  // Next register-file contents; entry 0 is pinned to zero
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we_eff) begin
      regs_d[A3] = WD;
    end
    regs_d[0] = '0;
  end

  // Register file state; asynchronous clear drops any write pending on that edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port 1 with write-through so decode sees this cycle's commit
  always_comb begin
    RD1 = '0;
    if (A1 != 5'd0) begin
      if (we_eff && (A1 == A3)) begin
        RD1 = WD;
      end else begin
        RD1 = regs_q[A1];
      end
    end
  end

  // Read port 2, independent of port 1
  always_comb begin
    RD2 = '0;
    if (A2 != 5'd0) begin
      if (we_eff && (A2 == A3)) begin
        RD2 = WD;
      end else begin
        RD2 = regs_q[A2];
      end
    end
  end

  // Trace record loads only on a commit; otherwise the last commit is held
  always_comb begin
    trace_we_d   = we_eff;
    trace_addr_d = trace_addr_q;
    trace_data_d = trace_data_q;
    trace_pc_d   = trace_pc_q;
    if (we_eff) begin
      trace_addr_d = A3;
      trace_data_d = WD;
      trace_pc_d   = W_PC;
    end
  end

  // Every valid W instruction retires, writer or not; wraps naturally at 2^32
  always_comb begin
    instret_d = instret_q + {31'd0, W_valid};
  end

  // Trace and retire-counter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_we_q   <= 1'b0;
      trace_addr_q <= '0;
      trace_data_q <= '0;
      trace_pc_q   <= '0;
      instret_q    <= '0;
    end else begin
      trace_we_q   <= trace_we_d;
      trace_addr_q <= trace_addr_d;
      trace_data_q <= trace_data_d;
      trace_pc_q   <= trace_pc_d;
      instret_q    <= instret_d;
    end
  end

  assign trace_we   = trace_we_q;
  assign trace_addr = trace_addr_q;
  assign trace_data = trace_data_q;
  assign trace_pc   = trace_pc_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_grf_writeback.sv
module tb_grf_writeback;

  logic        clk;
  logic        reset;
  logic        W_valid;
  logic        RFWr;
  logic [1:0]  WDSel;
  logic [4:0]  A3;
  logic [31:0] AO;
  logic [31:0] DR;
  logic [31:0] W_PC;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WD;
  logic        we_eff;
  logic        trace_we;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [31:0] trace_pc;
  logic [31:0] instret;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } tr_t;

  tr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  grf_writeback #(.WIDTH(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .W_valid(W_valid), .RFWr(RFWr), .WDSel(WDSel),
    .A3(A3), .AO(AO), .DR(DR), .W_PC(W_PC), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .WD(WD), .we_eff(we_eff),
    .trace_we(trace_we), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_pc(trace_pc), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rfwr, input logic [1:0] sel,
                       input logic [4:0] a3, input logic [31:0] ao,
                       input logic [31:0] dr, input logic [31:0] pc);
    W_valid = v;
    RFWr    = rfwr;
    WDSel   = sel;
    A3      = a3;
    AO      = ao;
    DR      = dr;
    W_PC    = pc;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic expect_commit(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    tr_t t;
    t.addr = a;
    t.data = d;
    t.pc   = pc;
    exp_q.push_back(t);
  endtask

  // Monitor: every cycle the trace reports a commit, pop and compare one record
  initial begin
    tr_t t;
    forever begin
      @(posedge clk);
      #1;
      if (reset && trace_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL trace_unexpected: got addr %0d data %h, expected no commit", trace_addr, trace_data);
        end else begin
          t = exp_q.pop_front();
          chk("trace_addr", {27'd0, trace_addr}, {27'd0, t.addr});
          chk("trace_data", trace_data, t.data);
          chk("trace_pc",   trace_pc,   t.pc);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    A1 = 5'd0;
    A2 = 5'd0;
    bubble();

    // Held in reset: everything reads zero
    #3;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      #1;
      chk("rst_rd1", RD1, 32'd0);
    end
    chk("rst_instret", instret, 32'd0);
    chk("rst_trace_we", {31'd0, trace_we}, 32'd0);
    chk("rst_trace_data", trace_data, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      #1;
      chk("post_rst_rd1", RD1, 32'd0);
      chk("post_rst_rd2", RD2, 32'd0);
    end

    // Write r5 via AO
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 5'd5, 32'h1234_5678, 32'h0, 32'h0000_1000);
    A1 = 5'd0;
    A2 = 5'd0;
    #1;
    chk("ao_wd", WD, 32'h1234_5678);
    chk("ao_we_eff", {31'd0, we_eff}, 32'd1);
    expect_commit(5'd5, 32'h1234_5678, 32'h0000_1000);
    @(negedge clk);
    bubble();
    A1 = 5'd5;
    #1;
    chk("ao_rd1", RD1, 32'h1234_5678);
    chk("ao_trace_we", {31'd0, trace_we}, 32'd1);
    chk("ao_trace_addr", {27'd0, trace_addr}, 32'd5);
    chk("ao_instret", instret, 32'd1);

    // Same-cycle write-through on both ports
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 5'd9, 32'hDEAD_BEEF, 32'h0, 32'h0000_1004);
    A1 = 5'd9;
    A2 = 5'd9;
    #1;
    chk("byp_rd1", RD1, 32'hDEAD_BEEF);
    chk("byp_rd2", RD2, 32'hDEAD_BEEF);
    expect_commit(5'd9, 32'hDEAD_BEEF, 32'h0000_1004);
    @(negedge clk);
    bubble();
    #1;
    chk("byp_arr_rd1", RD1, 32'hDEAD_BEEF);
    chk("byp_instret", instret, 32'd2);

    // jal link into r31
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b10, 5'd31, 32'h0000_0BAD, 32'h0, 32'h0000_3000);
    A1 = 5'd0;
    A2 = 5'd0;
    #1;
    chk("link_wd", WD, 32'h0000_3008);
    chk("link_we_eff", {31'd0, we_eff}, 32'd1);
    expect_commit(5'd31, 32'h0000_3008, 32'h0000_3000);
    @(negedge clk);
    bubble();
    A1 = 5'd31;
    #1;
    chk("link_rd1", RD1, 32'h0000_3008);
    chk("link_instret", instret, 32'd3);

    // Writes to $0 are discarded
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0000_3004);
    A1 = 5'd0;
    #1;
    chk("r0_we_eff", {31'd0, we_eff}, 32'd0);
    chk("r0_rd1_now", RD1, 32'd0);
    @(negedge clk);
    bubble();
    #1;
    chk("r0_rd1_after", RD1, 32'd0);
    chk("r0_instret", instret, 32'd4);
    chk("r0_trace_we", {31'd0, trace_we}, 32'd0);

    // Bubble with RFWr high
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 5'd7, 32'h0000_AAAA, 32'h0, 32'h0000_3008);
    #1;
    chk("bub_we_eff", {31'd0, we_eff}, 32'd0);
    @(negedge clk);
    bubble();
    A1 = 5'd7;
    #1;
    chk("bub_rd1", RD1, 32'd0);
    chk("bub_instret", instret, 32'd4);

    // Valid store: retires, no write, trace holds last commit
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 5'd8, 32'h0000_0055, 32'h0, 32'h0000_300C);
    #1;
    chk("st_we_eff", {31'd0, we_eff}, 32'd0);
    @(negedge clk);
    bubble();
    A1 = 5'd8;
    #1;
    chk("st_rd1", RD1, 32'd0);
    chk("st_instret", instret, 32'd5);
    chk("st_trace_we", {31'd0, trace_we}, 32'd0);
    chk("st_trace_addr_hold", {27'd0, trace_addr}, 32'd31);
    chk("st_trace_data_hold", trace_data, 32'h0000_3008);

    // Reserved select: no write, still retires
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b11, 5'd10, 32'h0000_0077, 32'h0, 32'h0000_3010);
    #1;
    chk("rsv_wd", WD, 32'd0);
    chk("rsv_we_eff", {31'd0, we_eff}, 32'd0);
    @(negedge clk);
    bubble();
    A1 = 5'd10;
    #1;
    chk("rsv_rd1", RD1, 32'd0);
    chk("rsv_instret", instret, 32'd6);
    chk("rsv_trace_we", {31'd0, trace_we}, 32'd0);

    // Counter wrap from a forced all-ones value
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("wrap_pre", instret, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0000_2004);
    @(negedge clk);
    bubble();
    #1;
    chk("wrap_instret", instret, 32'd0);

    // Write r3 via DR
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b01, 5'd3, 32'h0000_0099, 32'h0000_0007, 32'h0000_2000);
    A1 = 5'd0;
    A2 = 5'd0;
    #1;
    chk("dr_wd", WD, 32'h0000_0007);
    expect_commit(5'd3, 32'h0000_0007, 32'h0000_2000);
    @(negedge clk);
    bubble();
    A2 = 5'd3;
    #1;
    chk("dr_rd2", RD2, 32'h0000_0007);
    chk("dr_instret", instret, 32'd1);

    // Mid-run asynchronous reset, with a write to r4 pending on the next edge
    @(negedge clk);
    bubble();
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 5'd4, 32'h0000_4444, 32'h0, 32'h0000_2008);
    A1 = 5'd3;
    A2 = 5'd0;
    #1;
    reset = 1'b0;
    #1;
    chk("mrst_r3", RD1, 32'd0);
    chk("mrst_instret", instret, 32'd0);
    chk("mrst_trace_addr", {27'd0, trace_addr}, 32'd0);
    chk("mrst_trace_pc", trace_pc, 32'd0);
    @(negedge clk);
    bubble();
    reset = 1'b1;
    A1 = 5'd4;
    #1;
    chk("mrst_lost_write", RD1, 32'd0);
    chk("mrst_instret_after", instret, 32'd0);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
